dmem_store_checker: RTL and testbench
=====================================

Name: dmem_store_checker

Overview:
Parametrised, reusable self-checking monitor for CPU_top simulations. It generalises the single-word DataMem probe used by the CPU bench into an ordered expectation table.
- Snoops the data-memory store port.
- Compares every store, in program order, against a preloaded table of expected (address, data, byte-enable) entries.
- Produces a registered pass/fail verdict with a failure code and a timeout.
- Instantiated beside CPU_top; its verdict replaces ad-hoc hierarchical memory peeks.

Parameters:
AW, 32, address width
DW, 32, data width; DW/8 byte lanes
DEPTH, 8, expectation table entries (power of two)
TIMEOUT, 1000, cycles allowed in RUN before declaring failure
FILTER_BASE, 0, base of checked address window (used only with CHK_ADDR_FILTER_EN)
FILTER_SIZE, 4096, size in bytes of checked window (used only with CHK_ADDR_FILTER_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; IDLE -> RUN
exp_valid  in  1  expectation push request
exp_ready  out  1  table accepts a push this cycle
exp_addr  in  AW  expected store address
exp_data  in  DW  expected store data
exp_be  in  DW/8  expected byte enables
st_en  in  1  snooped store strobe, at most one store per cycle
st_addr  in  AW  snooped store address
st_data  in  DW  snooped store data
st_be  in  DW/8  snooped byte enables
busy  out  1  state == RUN
done  out  1  pass | fail
pass  out  1  all expectations matched
fail  out  1  check failed
fail_code  out  2  0 none, 1 data/be mismatch, 2 address mismatch, 3 timeout
fail_idx  out  $clog2(DEPTH)+1  index of the entry being checked at failure
fail_data  out  DW  observed st_data at failure (0 on timeout)
cycle_cnt  out  32  cycles spent in RUN, saturating

Behaviour:
Reset:
- One clock; reset is asynchronous and active-high.
- rst clears all outputs, the table, and the pointers. State = IDLE.
- Reset mid-RUN or in a terminal state discards everything; the table must be reloaded.

States:
- IDLE, RUN, PASS, FAIL. PASS and FAIL are terminal until rst.

IDLE:
- exp_ready = (count < DEPTH).
- A push occurs on exp_valid & exp_ready; entries are stored FIFO order.
- Stores are ignored.
- On start: count == 0 -> PASS next cycle (vacuous); otherwise -> RUN with cycle_cnt = 0.

RUN:
- exp_ready = 0.
- cycle_cnt increments every cycle, saturating at 2^32-1.
- Qualified store (st_en, plus the window check under the macro) is compared against the head entry:
  - st_addr != exp_addr -> FAIL, code 2. Address mismatch has priority over data mismatch.
  - Else st_be != exp_be, or (st_data ^ exp_data) nonzero in any enabled byte lane -> FAIL, code 1.
  - Else match: pop the head and increment the index. If it was the last entry -> PASS.
- Timeout: cycle_cnt == TIMEOUT-1 with entries remaining -> FAIL, code 3.
- If the final match and the timeout occur in the same cycle, the match wins (PASS).

Verdict timing:
- Registered. pass/fail/fail_* update on the clock edge that consumes the deciding store, so they are visible one cycle after st_en.

Terminal states:
- PASS/FAIL: start, pushes and stores are ignored.
- fail_* fields hold their values.
- cycle_cnt freezes.

Widths:
- Index and count are $clog2(DEPTH)+1 bits.
- Read/write pointers wrap modulo DEPTH.

Optional Feature:
CHK_ADDR_FILTER_EN:
- Defined: only stores with FILTER_BASE <= st_addr < FILTER_BASE+FILTER_SIZE are checked. Stores outside the window are ignored completely (no compare, no fail).
- Undefined: every st_en store is checked, and FILTER_* parameters are unused.

Test Plan:
1. Push {0x4, 0x00000055, 0xF}; start; store the same tuple on RUN cycle 3 -> pass=1 next cycle, fail_code=0, cycle_cnt=4.
2. Push {0x4, 0x55, 0xF}; store {0x4, 0x54, 0xF} -> fail=1, fail_code=1, fail_idx=0, fail_data=0x54. Also store {0x4, 0x55, 0x1} when expecting be 0xF -> code 1.
3. Push entries for addr 0x4 then 0x8; store 0x8 first -> fail, code 2, idx 0. Same stores in correct order -> pass.
4. TIMEOUT=20, one entry, no stores -> fail_code=3 asserted when cycle_cnt reaches 19, done=1, fail_data=0. Final match on cycle 19 -> pass.
5. Attempt DEPTH+1 pushes -> exp_ready drops after 8 and the 9th is not accepted; 8 ordered matching stores -> pass. Reset asserted mid-RUN after 3 matches -> all outputs 0, IDLE, exp_ready=1.
6. With CHK_ADDR_FILTER_EN, window 0x0-0xFFF: mismatching store to 0x2000 is ignored and the expected store to 0x4 then passes. Without the macro, the same sequence fails with code 2.

Source files
------------

// File: rtl/dmem_store_checker.sv
// Ordered data-memory store checker: compares snooped stores against a preloaded FIFO of expectations.
// Optional CHK_ADDR_FILTER_EN restricts checking to the FILTER_BASE/FILTER_SIZE address window.
module dmem_store_checker #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 1000,
  parameter int FILTER_BASE = 0,
  parameter int FILTER_SIZE = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [AW-1:0]            exp_addr,
  input  logic [DW-1:0]            exp_data,
  input  logic [DW/8-1:0]          exp_be,
  input  logic                     st_en,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [DW/8-1:0]          st_be,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               fail_code,
  output logic [$clog2(DEPTH):0]   fail_idx,
  output logic [DW-1:0]            fail_data,
  output logic [31:0]              cycle_cnt
);
  localparam int BW = DW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int IW = PW + 1;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t          state;
  logic [AW-1:0]   tab_addr [DEPTH];
  logic [DW-1:0]   tab_data [DEPTH];
  logic [BW-1:0]   tab_be   [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [IW-1:0]   count, idx;
  logic [DW-1:0]   lane_mask;
  logic            qual, addr_bad, lane_bad, push, timeout_hit;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BW; i++) lane_mask[i*8 +: 8] = {8{tab_be[rd_ptr][i]}};
  end

`ifdef CHK_ADDR_FILTER_EN
  localparam logic [AW:0] WIN_LO = (AW+1)'(FILTER_BASE);
  localparam logic [AW:0] WIN_HI = (AW+1)'(FILTER_BASE) + (AW+1)'(FILTER_SIZE);
  assign qual = st_en && ({1'b0, st_addr} >= WIN_LO) && ({1'b0, st_addr} < WIN_HI);
`else
  assign qual = st_en;
`endif

  assign addr_bad    = st_addr != tab_addr[rd_ptr];
  assign lane_bad    = (st_be != tab_be[rd_ptr]) || (|((st_data ^ tab_data[rd_ptr]) & lane_mask));
  assign timeout_hit = cycle_cnt == TO_LAST;
  assign exp_ready   = (state == ST_IDLE) && (count < IW'(DEPTH));
  assign push        = exp_valid && exp_ready;
  assign busy        = state == ST_RUN;
  assign done        = pass | fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      idx       <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'd0;
      fail_idx  <= '0;
      fail_data <= '0;
      cycle_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tab_addr[i] <= '0;
        tab_data[i] <= '0;
        tab_be[i]   <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (push) begin
            tab_addr[wr_ptr] <= exp_addr;
            tab_data[wr_ptr] <= exp_data;
            tab_be[wr_ptr]   <= exp_be;
            wr_ptr           <= wr_ptr + 1'b1;
            count            <= count + 1'b1;
          end
          if (start) begin
            if (count == '0) begin
              state <= ST_PASS;
              pass  <= 1'b1;
            end else begin
              state     <= ST_RUN;
              cycle_cnt <= '0;
            end
          end
        end
        ST_RUN: begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          if (qual && addr_bad) begin
            state     <= ST_FAIL;
            fail      <= 1'b1;
            fail_code <= 2'd2;
            fail_idx  <= idx;
            fail_data <= st_data;
          end else if (qual && lane_bad) begin
            state     <= ST_FAIL;
            fail      <= 1'b1;
            fail_code <= 2'd1;
            fail_idx  <= idx;
            fail_data <= st_data;
          end else if (qual && count == IW'(1)) begin
            // final match beats a same-cycle timeout
            state <= ST_PASS;
            pass  <= 1'b1;
          end else if (timeout_hit) begin
            state     <= ST_FAIL;
            fail      <= 1'b1;
            fail_code <= 2'd3;
            fail_idx  <= idx + IW'(qual);
            fail_data <= '0;
          end
          if (qual && !addr_bad && !lane_bad) begin
            rd_ptr <= rd_ptr + 1'b1;
            idx    <= idx + 1'b1;
            count  <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_store_checker.sv
// Directed bench for dmem_store_checker (TIMEOUT=20); covers match, mismatch codes, timeout, full table, reset, filter.
module tb_dmem_store_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_ready;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [3:0]  exp_be = '0;
  logic        st_en = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_be = '0;
  logic        busy, done, pass, fail;
  logic [1:0]  fail_code;
  logic [3:0]  fail_idx;
  logic [31:0] fail_data;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  dmem_store_checker #(.TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_be(exp_be),
    .st_en(st_en), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_code(fail_code), .fail_idx(fail_idx), .fail_data(fail_data),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // inputs change only at negedge; each tick lets exactly one posedge pass
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_addr = a; exp_data = d; exp_be = b; exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    st_addr = a; st_data = d; st_be = b; st_en = 1'b1;
    tick();
    st_en = 1'b0;
  endtask

  initial begin
    tick();
    do_reset();
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", exp_ready, 1);
    check("rst_cnt", cycle_cnt, 0);

    // vacuous start
    go();
    check("vac_pass", pass, 1);
    check("vac_done", done, 1);

    // T1: single matching store on RUN cycle 3
    do_reset();
    push(32'h4, 32'h55, 4'hF);
    go();
    check("t1_busy", busy, 1);
    check("t1_ready_run", exp_ready, 0);
    repeat (3) tick();
    check("t1_cnt3", cycle_cnt, 3);
    store(32'h4, 32'h55, 4'hF);
    check("t1_pass", pass, 1);
    check("t1_code", fail_code, 0);
    check("t1_cnt", cycle_cnt, 4);
    check("t1_busy_off", busy, 0);
    tick(); tick();
    check("t1_cnt_frozen", cycle_cnt, 4);

    // T2: data mismatch, then byte-enable mismatch
    do_reset();
    push(32'h4, 32'h55, 4'hF);
    go();
    store(32'h4, 32'h54, 4'hF);
    check("t2_fail", fail, 1);
    check("t2_code", fail_code, 1);
    check("t2_idx", fail_idx, 0);
    check("t2_data", fail_data, 32'h54);
    store(32'h8, 32'h99, 4'hF);
    check("t2_hold_code", fail_code, 1);
    check("t2_hold_data", fail_data, 32'h54);
    do_reset();
    push(32'h4, 32'h55, 4'hF);
    go();
    store(32'h4, 32'h55, 4'h1);
    check("t2b_code", fail_code, 1);

    // T3: out-of-order stores, then in-order
    do_reset();
    push(32'h4, 32'h11, 4'hF);
    push(32'h8, 32'h22, 4'hF);
    go();
    store(32'h8, 32'h22, 4'hF);
    check("t3_fail", fail, 1);
    check("t3_code", fail_code, 2);
    check("t3_idx", fail_idx, 0);
    do_reset();
    push(32'h4, 32'h11, 4'hF);
    push(32'h8, 32'h22, 4'hF);
    go();
    store(32'h4, 32'h11, 4'hF);
    check("t3_mid_pass", pass, 0);
    store(32'h8, 32'h22, 4'hF);
    check("t3_pass", pass, 1);
    // masked-off lanes are don't-care; wrong data in the second entry reports idx 1
    do_reset();
    push(32'h4, 32'h0000_00AA, 4'h1);
    push(32'h8, 32'h22, 4'hF);
    go();
    store(32'h4, 32'hFFFF_FFAA, 4'h1);
    check("t3c_lane_ok", fail, 0);
    store(32'h8, 32'h23, 4'hF);
    check("t3c_code", fail_code, 1);
    check("t3c_idx", fail_idx, 1);

    // T4: timeout at cycle 19, and final match on cycle 19 wins
    do_reset();
    push(32'h4, 32'h55, 4'hF);
    go();
    repeat (19) tick();
    check("t4_cnt19", cycle_cnt, 19);
    check("t4_not_yet", fail, 0);
    tick();
    check("t4_fail", fail, 1);
    check("t4_code", fail_code, 3);
    check("t4_done", done, 1);
    check("t4_data", fail_data, 0);
    check("t4_idx", fail_idx, 0);
    do_reset();
    push(32'h4, 32'h55, 4'hF);
    go();
    repeat (19) tick();
    store(32'h4, 32'h55, 4'hF);
    check("t4b_pass", pass, 1);
    check("t4b_nofail", fail, 0);

    // T5: full table, rejected 9th push, ordered stores
    do_reset();
    for (int i = 0; i < 8; i++) push(32'(4 * i), 32'(8'h11 * i), 4'hF);
    check("t5_full", exp_ready, 0);
    push(32'h100, 32'hBAD, 4'hF);
    go();
    for (int i = 0; i < 8; i++) store(32'(4 * i), 32'(8'h11 * i), 4'hF);
    check("t5_pass", pass, 1);
    check("t5_nofail", fail, 0);
    // asynchronous reset mid-RUN
    do_reset();
    for (int i = 0; i < 8; i++) push(32'(4 * i), 32'(8'h11 * i), 4'hF);
    go();
    for (int i = 0; i < 3; i++) store(32'(4 * i), 32'(8'h11 * i), 4'hF);
    check("t5_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_cnt", cycle_cnt, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_ready", exp_ready, 1);
    tick();
    rst = 1'b0;
    go();
    check("t5_reload_vac", pass, 1);

    // T6: store outside the window
    do_reset();
    push(32'h4, 32'h55, 4'hF);
    go();
    store(32'h2000, 32'hDEAD, 4'hF);
`ifdef CHK_ADDR_FILTER_EN
    check("t6_ignored", fail, 0);
    store(32'h4, 32'h55, 4'hF);
    check("t6_pass", pass, 1);
`else
    check("t6_fail", fail, 1);
    check("t6_code", fail_code, 2);
    check("t6_data", fail_data, 32'hDEAD);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
